dcache_setassoc: RTL and testbench
==================================

DCACHE_SETASSOC -- requirements
Module: dcache_setassoc

Interface
REQ-001 WORDS_PER_LINE, 16, 64-bit words per line; power of two, 2..16; burst length encoded on creq.len.
REQ-002 ASSOCIATIVITY, 2, ways per set; power of two, 1..8.
REQ-003 SET_NUM, 8, sets; power of two, >=2.
REQ-004 UNCACHED_BIT, 31, address bit; addr[UNCACHED_BIT]==0 marks an uncached (MMIO) access.
REQ-005 clk  input  1  clock; one clock; reset is synchronous and active-low.
REQ-006 reset  input  1  synchronous active-low reset.
REQ-007 dreq  input  dbus_req_t  CPU request (valid, addr, size, strobe, data); requester holds it stable until dresp.data_ok.
REQ-008 dresp  output  dbus_resp_t  addr_ok, data_ok, data.
REQ-009 creq  output  cbus_req_t  memory request (valid, is_write, size, addr, strobe, data, len, burst).
REQ-010 cresp  input  cbus_resp_t  ready, last, data.

Function
REQ-011 Address split: offset=addr[3+OB-1:3], index=next IB bits, tag=remaining upper bits; OB=log2(WORDS_PER_LINE), IB=log2(SET_NUM).
REQ-012 Storage: data in one RAM_SinglePort (READ_LATENCY 0, 64-bit, byte strobes), word address {index, way, offset}; per-line valid, dirty, tag and LRU age in flip-flops.
REQ-013 States: IDLE, LOOKUP, WRITEBACK, FETCH, UNCACHED.
REQ-014 IDLE: dreq.valid -> latch dreq; addr[UNCACHED_BIT]==0 -> UNCACHED, else -> LOOKUP; dresp and creq.valid all 0.
REQ-015 LOOKUP hit (valid way with matching tag): addr_ok=data_ok=1 this cycle; data=stored word before any merge; |strobe -> write strobed bytes, set dirty; update LRU; -> IDLE. Hit latency: accepted cycle T, data_ok T+1.
REQ-016 LOOKUP miss: victim = lowest-index invalid way, else way with maximum age; latch victim; victim valid and dirty -> WRITEBACK, else -> FETCH; no dresp.
REQ-017 WRITEBACK: creq valid=1, is_write=1, size MSIZE8, addr={victim tag, index, 0}, len=WORDS_PER_LINE, burst INCR, strobe 8'hFF, data=RAM word {index, victim, beat}; beat++ on cresp.ready; ready&&last -> FETCH, beat=0.
REQ-018 FETCH: creq valid=1, is_write=0, addr={req tag, index, 0}, same size/len/burst; each cresp.ready writes cresp.data to {index, victim, beat} with strobe 8'hFF, beat++; ready&&last -> victim valid=1, dirty=0, tag=req tag, beat=0, -> LOOKUP (hits next cycle; write misses merge there).
REQ-019 UNCACHED: creq valid=1, is_write=|req.strobe, size=req.size, addr=req.addr, strobe=req.strobe, data=req.data, len MLEN1, burst FIXED; on ready&&last: addr_ok=data_ok=1, data=cresp.data, -> IDLE; no RAM or metadata change.
REQ-020 creq fields held constant for a whole burst; cresp.ready low stalls beat counter and state; creq outputs zero when creq.valid=0.
REQ-021 LRU: ages are a permutation of 0..ASSOCIATIVITY-1 per set; on hit of way w, ways with age<age[w] increment, age[w]=0; ASSOCIATIVITY=1 -> victim always way 0.
REQ-022 dreq changes after acceptance are ignored; next request accepted in IDLE the cycle after data_ok (one bubble).
REQ-023 Beat counter width OB bits; wraps to 0 on last beat only.

Reset
REQ-024 reset low at a clk edge: state=IDLE, all valid=0, dirty=0, tags=0, age of way i = i, beat=0, latched request cleared; dresp and creq.valid 0 from next cycle.
REQ-025 Reset mid-burst abandons the burst (bus reset concurrently); data RAM contents not cleared.

Verification (defaults: 128 B lines, 1 KiB set stride)
REQ-026 Read 0x8000_0000 after reset -> FETCH burst addr 0x8000_0000, 16 beats data k=0..15; data_ok one cycle after last, data 0; read 0x8000_0008 -> data_ok T+1, data 1, no creq.
REQ-027 Stored 0xAAAA_AAAA_AAAA_AAAA at 0x8000_0010; write strobe 8'h0F data 0x1122_3344_5566_7788 -> hit, no creq; read back 0xAAAA_AAAA_5566_7788.
REQ-028 Write 0x8000_0000, read 0x8000_0400, read 0x8000_0000, read 0x8000_0800 -> evicts 0x8000_0400 without writeback; read 0x8000_0C00 -> WRITEBACK burst at 0x8000_0000 carrying written data, then FETCH 0x8000_0C00.
REQ-029 Write 0x1000_0000 size MSIZE1 strobe 8'h01 -> single beat, len MLEN1, burst FIXED, is_write=1; data_ok with cresp.last; read same address returns cresp.data, no RAM update.
REQ-030 cresp.ready low 3 cycles mid-FETCH -> beat and addr frozen, no skipped or duplicated beats; reset low at beat 5 of WRITEBACK -> IDLE, creq.valid 0 next cycle, prior lines all miss.

Source files
------------

// File: rtl/dcache_setassoc.sv
// Set-associative write-back data cache between a CPU data bus and a burst memory bus.
// Ports: clk, reset (sync, active-low), dreq/dresp (CPU side), creq/cresp (memory side).
// Cached lines live in one zero-latency single-port RAM addressed {index, way, offset};
// valid/dirty/tag/LRU age live in flops. addr[UNCACHED_BIT]==0 bypasses the cache.

package dcache_pkg;
    typedef logic [2:0] msize_t;
    typedef logic [3:0] mlen_t;
    typedef logic [1:0] mburst_t;

    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;
    localparam msize_t MSIZE8 = 3'd3;
    localparam mlen_t MLEN1 = 4'd0;
    localparam mlen_t MLEN16 = 4'd15;
    localparam mburst_t BURST_FIXED = 2'd0;
    localparam mburst_t BURST_INCR = 2'd1;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        mburst_t     burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

// Zero-read-latency single-port RAM with byte write strobes; contents are never reset.
module ram_single_port #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            strobe,
    input  logic [63:0]           wdata,
    output logic [63:0]           rdata
);
    logic [63:0] mem [2**ADDR_WIDTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (strobe[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
endmodule

// State   | meaning
// IDLE    | waiting for a CPU request
// LOOKUP  | tag compare; hit answers the CPU, miss picks a victim
// WRITEBACK | burst the dirty victim line out to memory
// FETCH   | burst the requested line in from memory
// UNCACHED| single-beat pass-through access
module dcache_setassoc
    import dcache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 16,
    parameter int ASSOCIATIVITY  = 2,
    parameter int SET_NUM        = 8,
    parameter int UNCACHED_BIT   = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);
    localparam int OB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(SET_NUM);
    localparam int WB = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;
    localparam int TB = 32 - 3 - OB - IB;
    localparam int AW = IB + WB + OB;
    localparam mlen_t LINE_LEN = 4'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FETCH, UNCACHED} state_t;

    state_t state, state_next;
    logic [31:0] req_addr;
    msize_t      req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic [OB-1:0] beat;
    logic [WB-1:0] victim;

    logic [SET_NUM-1:0][ASSOCIATIVITY-1:0]         valid_q, dirty_q;
    logic [SET_NUM-1:0][ASSOCIATIVITY-1:0][TB-1:0] tag_q;
    logic [SET_NUM-1:0][ASSOCIATIVITY-1:0][WB-1:0] age_q;

    logic [OB-1:0] req_off;
    logic [IB-1:0] req_idx;
    logic [TB-1:0] req_tag;
    assign req_off = req_addr[3 +: OB];
    assign req_idx = req_addr[3+OB +: IB];
    assign req_tag = req_addr[3+OB+IB +: TB];

    logic          hit, inv_found;
    logic [WB-1:0] hit_way, vsel;
    logic          last_beat;
    assign last_beat = cresp.ready && cresp.last;

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        inv_found = 1'b0;
        vsel = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (!hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit = 1'b1;
                hit_way = WB'(w);
            end
            if (!inv_found && !valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                vsel = WB'(w);
            end
        end
        // With all ways valid the oldest line (age == ASSOCIATIVITY-1) goes.
        if (!inv_found) begin
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                if (age_q[req_idx][w] == WB'(ASSOCIATIVITY - 1)) vsel = WB'(w);
            end
        end
    end

    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_strobe;
    logic [63:0]   ram_wdata, ram_rdata;

    always_comb begin
        ram_addr = {req_idx, hit_way, req_off};
        ram_strobe = 8'h00;
        ram_wdata = req_data;
        case (state)
            LOOKUP: if (hit) ram_strobe = req_strobe;
            WRITEBACK: ram_addr = {req_idx, victim, beat};
            FETCH: begin
                ram_addr = {req_idx, victim, beat};
                ram_wdata = cresp.data;
                if (cresp.ready) ram_strobe = 8'hFF;
            end
            default: ;
        endcase
    end

    ram_single_port #(.ADDR_WIDTH(AW)) u_ram (
        .clk(clk), .addr(ram_addr), .strobe(ram_strobe), .wdata(ram_wdata), .rdata(ram_rdata)
    );

    always_comb begin
        state_next = state;
        dresp = '0;
        creq = '0;
        case (state)
            IDLE: if (dreq.valid) state_next = dreq.addr[UNCACHED_BIT] ? LOOKUP : UNCACHED;
            LOOKUP: begin
                if (hit) begin
                    dresp.addr_ok = 1'b1;
                    dresp.data_ok = 1'b1;
                    dresp.data = ram_rdata;
                    state_next = IDLE;
                end else if (valid_q[req_idx][vsel] && dirty_q[req_idx][vsel]) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = FETCH;
                end
            end
            WRITEBACK: begin
                creq.valid = 1'b1;
                creq.is_write = 1'b1;
                creq.size = MSIZE8;
                creq.addr = {tag_q[req_idx][victim], req_idx, {(OB+3){1'b0}}};
                creq.strobe = 8'hFF;
                creq.data = ram_rdata;
                creq.len = LINE_LEN;
                creq.burst = BURST_INCR;
                if (last_beat) state_next = FETCH;
            end
            FETCH: begin
                creq.valid = 1'b1;
                creq.size = MSIZE8;
                creq.addr = {req_tag, req_idx, {(OB+3){1'b0}}};
                creq.len = LINE_LEN;
                creq.burst = BURST_INCR;
                if (last_beat) state_next = LOOKUP;
            end
            UNCACHED: begin
                creq.valid = 1'b1;
                creq.is_write = |req_strobe;
                creq.size = req_size;
                creq.addr = req_addr;
                creq.strobe = req_strobe;
                creq.data = req_data;
                creq.len = MLEN1;
                creq.burst = BURST_FIXED;
                if (last_beat) begin
                    dresp.addr_ok = 1'b1;
                    dresp.data_ok = 1'b1;
                    dresp.data = cresp.data;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            req_addr <= '0;
            req_size <= '0;
            req_strobe <= '0;
            req_data <= '0;
            beat <= '0;
            victim <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            tag_q <= '0;
            for (int s = 0; s < SET_NUM; s++)
                for (int w = 0; w < ASSOCIATIVITY; w++)
                    age_q[s][w] <= WB'(w);
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (dreq.valid) begin
                    req_addr <= dreq.addr;
                    req_size <= dreq.size;
                    req_strobe <= dreq.strobe;
                    req_data <= dreq.data;
                end
                LOOKUP: begin
                    if (hit) begin
                        if (|req_strobe) dirty_q[req_idx][hit_way] <= 1'b1;
                        for (int w = 0; w < ASSOCIATIVITY; w++) begin
                            if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                                age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                        end
                        age_q[req_idx][hit_way] <= '0;
                    end else begin
                        victim <= vsel;
                    end
                end
                WRITEBACK: if (cresp.ready) beat <= cresp.last ? '0 : beat + 1'b1;
                FETCH: if (cresp.ready) begin
                    beat <= cresp.last ? '0 : beat + 1'b1;
                    if (cresp.last) begin
                        valid_q[req_idx][victim] <= 1'b1;
                        dirty_q[req_idx][victim] <= 1'b0;
                        tag_q[req_idx][victim] <= req_tag;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_setassoc.sv
module tb_dcache_setassoc;
    import dcache_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    dbus_req_t  dreq = '0;
    dbus_resp_t dresp;
    cbus_req_t  creq;
    cbus_resp_t cresp = '0;

    always #5 clk = ~clk;

    dcache_setassoc dut (
        .clk(clk), .reset(reset_n), .dreq(dreq), .dresp(dresp), .creq(creq), .cresp(cresp)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: sparse word store, default word = addr[30:3].
    logic [63:0] mem [logic [31:0]];
    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        logic [31:0] k = {a[31:3], 3'b000};
        return mem.exists(k) ? mem[k] : 64'(a[30:3]);
    endfunction
    function automatic void mem_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w = mem_rd(a);
        for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mem[{a[31:3], 3'b000}] = w;
    endfunction

    int bbeat = 0;
    int stall_beat = -1;
    int stall_left = 0;
    int held_err = 0;
    logic [31:0] b_addr[$];
    logic        b_wr[$];
    logic [3:0]  b_len[$];
    logic [1:0]  b_burst[$];
    logic [2:0]  b_size[$];
    int          b_beats[$];

    // Responder: updates cresp just after each rising edge, so the DUT sees it next edge.
    always @(posedge clk) begin
        logic [31:0] a;
        #1;
        if (!reset_n || !creq.valid) begin
            bbeat = 0;
            cresp = '0;
        end else if (bbeat == stall_beat && stall_left > 0) begin
            cresp = '0;
            stall_left--;
        end else begin
            a = (creq.burst == BURST_INCR) ? creq.addr + 32'(bbeat * 8) : creq.addr;
            if (bbeat == 0) begin
                b_addr.push_back(creq.addr);
                b_wr.push_back(creq.is_write);
                b_len.push_back(creq.len);
                b_burst.push_back(creq.burst);
                b_size.push_back(creq.size);
                b_beats.push_back(0);
            end else if (creq.addr != b_addr[b_addr.size()-1]) begin
                held_err++;
            end
            cresp.ready = 1'b1;
            cresp.last = (bbeat == int'(creq.len));
            cresp.data = mem_rd(a);
            if (creq.is_write) mem_wr(a, creq.data, creq.strobe);
            b_beats[b_beats.size()-1]++;
            bbeat = cresp.last ? 0 : bbeat + 1;
        end
    end

    task automatic do_access(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] strb,
                             input logic [63:0] wdata, output logic [63:0] rdata, output int lat,
                             output bit timeout, output bit aok);
        @(negedge clk);
        dreq.valid = 1'b1;
        dreq.addr = addr;
        dreq.size = size;
        dreq.strobe = strb;
        dreq.data = wdata;
        timeout = 1'b1;
        lat = 0;
        rdata = '0;
        aok = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (dresp.data_ok) begin
                lat = i;
                rdata = dresp.data;
                aok = dresp.addr_ok;
                timeout = 1'b0;
                break;
            end
        end
        dreq = '0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        int          exp_bursts;
        int          exp_lat;
        logic [31:0] exp_baddr;
        logic        exp_bwr;
    } vec_t;

    initial begin
        vec_t vecs[13];
        int nb_at[13];
        logic [63:0] rd;
        int lat, nb;
        bit to, aok;

        vecs[0]  = '{"rd_80000000_miss", 32'h8000_0000, MSIZE8, 8'h00, 64'h0, 64'h0, 1, 18, 32'h8000_0000, 1'b0};
        vecs[1]  = '{"rd_80000008_hit", 32'h8000_0008, MSIZE8, 8'h00, 64'h0, 64'h1, 0, 1, 32'h0, 1'b0};
        vecs[2]  = '{"wr_aaaa_full", 32'h8000_0010, MSIZE8, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'h2, 0, 1, 32'h0, 1'b0};
        vecs[3]  = '{"wr_strobe_0f", 32'h8000_0010, MSIZE8, 8'h0F, 64'h1122_3344_5566_7788, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1, 32'h0, 1'b0};
        vecs[4]  = '{"rd_merged", 32'h8000_0010, MSIZE8, 8'h00, 64'h0, 64'hAAAA_AAAA_5566_7788, 0, 1, 32'h0, 1'b0};
        vecs[5]  = '{"wr_80000000", 32'h8000_0000, MSIZE8, 8'hFF, 64'hDEAD_BEEF_0000_0001, 64'h0, 0, 1, 32'h0, 1'b0};
        vecs[6]  = '{"rd_80000400_fill_w1", 32'h8000_0400, MSIZE8, 8'h00, 64'h0, 64'h80, 1, 18, 32'h8000_0400, 1'b0};
        vecs[7]  = '{"rd_80000000_hit", 32'h8000_0000, MSIZE8, 8'h00, 64'h0, 64'hDEAD_BEEF_0000_0001, 0, 1, 32'h0, 1'b0};
        vecs[8]  = '{"rd_80000800_clean_evict", 32'h8000_0800, MSIZE8, 8'h00, 64'h0, 64'h100, 1, 18, 32'h8000_0800, 1'b0};
        vecs[9]  = '{"rd_80000c00_writeback", 32'h8000_0C00, MSIZE8, 8'h00, 64'h0, 64'h180, 2, 34, 32'h8000_0000, 1'b1};
        vecs[10] = '{"rd_80000000_refetch", 32'h8000_0000, MSIZE8, 8'h00, 64'h0, 64'hDEAD_BEEF_0000_0001, 1, 18, 32'h8000_0000, 1'b0};
        vecs[11] = '{"unc_wr_byte", 32'h1000_0000, MSIZE1, 8'h01, 64'h0000_0000_0000_00AB, 64'h0200_0000, 1, 1, 32'h1000_0000, 1'b1};
        vecs[12] = '{"unc_rd_byte", 32'h1000_0000, MSIZE1, 8'h00, 64'h0, 64'h0200_00AB, 1, 1, 32'h1000_0000, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_creq_valid", 64'(creq.valid), 64'h0);
        check("reset_data_ok", 64'(dresp.data_ok), 64'h0);
        check("reset_addr_ok", 64'(dresp.addr_ok), 64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            nb = b_addr.size();
            nb_at[i] = nb;
            do_access(vecs[i].addr, vecs[i].size, vecs[i].strb, vecs[i].wdata, rd, lat, to, aok);
            check({vecs[i].name, "_timeout"}, 64'(to), 64'h0);
            check({vecs[i].name, "_data"}, rd, vecs[i].exp_data);
            check({vecs[i].name, "_addr_ok"}, 64'(aok), 64'h1);
            check({vecs[i].name, "_bursts"}, 64'(b_addr.size() - nb), 64'(vecs[i].exp_bursts));
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
            if (vecs[i].exp_bursts > 0 && b_addr.size() > nb) begin
                check({vecs[i].name, "_burst_addr"}, 64'(b_addr[nb]), 64'(vecs[i].exp_baddr));
                check({vecs[i].name, "_burst_wr"}, 64'(b_wr[nb]), 64'(vecs[i].exp_bwr));
            end
        end

        if (b_addr.size() > nb_at[9] + 1 && b_addr.size() > nb_at[11]) begin
            check("fetch_len", 64'(b_len[nb_at[0]]), 64'(MLEN16));
            check("fetch_burst", 64'(b_burst[nb_at[0]]), 64'(BURST_INCR));
            check("fetch_size", 64'(b_size[nb_at[0]]), 64'(MSIZE8));
            check("fetch_beats", 64'(b_beats[nb_at[0]]), 64'd16);
            check("wb_beats", 64'(b_beats[nb_at[9]]), 64'd16);
            check("wb_then_fetch_addr", 64'(b_addr[nb_at[9] + 1]), 64'h8000_0C00);
            check("wb_then_fetch_wr", 64'(b_wr[nb_at[9] + 1]), 64'h0);
            check("unc_len", 64'(b_len[nb_at[11]]), 64'(MLEN1));
            check("unc_burst", 64'(b_burst[nb_at[11]]), 64'(BURST_FIXED));
            check("unc_size", 64'(b_size[nb_at[11]]), 64'(MSIZE1));
            check("unc_beats", 64'(b_beats[nb_at[11]]), 64'd1);
        end else begin
            check("burst_log_size", 64'(b_addr.size()), 64'(nb_at[11] + 1));
        end
        check("wb_mem_word0", mem_rd(32'h8000_0000), 64'hDEAD_BEEF_0000_0001);
        check("wb_mem_word2", mem_rd(32'h8000_0010), 64'hAAAA_AAAA_5566_7788);
        check("wb_mem_word1", mem_rd(32'h8000_0008), 64'h1);

        // Stalled fetch: ready held low for 3 cycles at beat 5.
        stall_beat = 5;
        stall_left = 3;
        nb = b_addr.size();
        do_access(32'h8000_1080, MSIZE8, 8'h00, 64'h0, rd, lat, to, aok);
        stall_beat = -1;
        check("stall_timeout", 64'(to), 64'h0);
        check("stall_data", rd, 64'h210);
        check("stall_latency", 64'(lat), 64'd21);
        check("stall_beats", 64'(b_addr.size() > nb ? b_beats[nb] : 0), 64'd16);
        for (int k = 4; k < 8; k++) begin
            int off = (k == 7) ? 15 : k;
            do_access(32'h8000_1080 + 32'(off * 8), MSIZE8, 8'h00, 64'h0, rd, lat, to, aok);
            check($sformatf("stall_word%0d", off), rd, 64'(32'h210 + 32'(off)));
        end
        check("creq_addr_held", 64'(held_err), 64'h0);

        // Dirty line in set 1, fill other way, then force a writeback and reset mid-burst.
        do_access(32'h8000_1088, MSIZE8, 8'hFF, 64'h5555_5555_5555_5555, rd, lat, to, aok);
        check("set1_write_hit_lat", 64'(lat), 64'd1);
        do_access(32'h8000_1480, MSIZE8, 8'h00, 64'h0, rd, lat, to, aok);
        check("set1_fill_w1", rd, 64'h290);
        nb = b_addr.size();
        @(negedge clk);
        dreq.valid = 1'b1;
        dreq.addr = 32'h8000_1880;
        dreq.size = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data = '0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bbeat == 6 && b_addr.size() > nb) begin
                to = 1'b0;
                break;
            end
        end
        check("rst_wb_reached_beat5", 64'(to), 64'h0);
        check("rst_wb_is_write", 64'(b_addr.size() > nb ? b_wr[nb] : 1'b0), 64'h1);
        reset_n = 1'b0;
        dreq = '0;
        @(negedge clk);
        check("rst_mid_creq_valid", 64'(creq.valid), 64'h0);
        check("rst_mid_data_ok", 64'(dresp.data_ok), 64'h0);
        reset_n = 1'b1;
        nb = b_addr.size();
        do_access(32'h8000_1480, MSIZE8, 8'h00, 64'h0, rd, lat, to, aok);
        check("post_rst_miss_bursts", 64'(b_addr.size() - nb), 64'h1);
        check("post_rst_miss_data", rd, 64'h290);
        check("post_rst_miss_lat", 64'(lat), 64'd18);
        nb = b_addr.size();
        do_access(32'h8000_0C00, MSIZE8, 8'h00, 64'h0, rd, lat, to, aok);
        check("post_rst_c00_bursts", 64'(b_addr.size() - nb), 64'h1);
        check("post_rst_c00_data", rd, 64'h180);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
